// File: rtl/register_write_bank.sv
`default_nettype none
// ============================================================================
//  Module   : register_write_bank
//  Purpose  : Write side of the 8 x 16-bit register bank. Requests are queued
//             in a small FIFO, committed byte-masked to q0..q7, with a
//             drain-then-sweep clear-all sequence.
//  Revision : 1.0  initial release
// ============================================================================
module register_write_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [1:0]               wr_be,
    input  logic                     clr_req,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [WIDTH-1:0]         q0,
    output logic [WIDTH-1:0]         q1,
    output logic [WIDTH-1:0]         q2,
    output logic [WIDTH-1:0]         q3,
    output logic [WIDTH-1:0]         q4,
    output logic [WIDTH-1:0]         q5,
    output logic [WIDTH-1:0]         q6,
    output logic [WIDTH-1:0]         q7
);

    localparam int               c_AW    = $clog2(DEPTH);
    localparam int               c_EW    = 3 + WIDTH + 2;
    localparam logic [c_AW:0]    c_FULL  = (c_AW + 1)'(DEPTH);
    localparam logic [1:0]       c_IDLE  = 2'd0;
    localparam logic [1:0]       c_DRAIN = 2'd1;
    localparam logic [1:0]       c_CLEAR = 2'd2;

    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic [1:0]       r_state;
    logic [2:0]       r_idx;
    logic             r_busy;
    logic [WIDTH-1:0] r_q [8];

    logic             w_push;
    logic             w_pop;
    logic [c_AW:0]    w_count_next;
    logic [1:0]       w_state_next;
    logic [c_EW-1:0]  w_head;
    logic [2:0]       w_head_addr;
    logic [WIDTH-1:0] w_head_data;
    logic [1:0]       w_head_be;

    assign wr_ready    = !rst && (r_state == c_IDLE) && (r_count != c_FULL);
    assign w_push      = wr_valid && wr_ready;
    assign w_pop       = (r_state != c_CLEAR) && (r_count != '0);
    assign w_head      = r_mem[r_rptr];
    assign w_head_addr = w_head[c_EW-1 -: 3];
    assign w_head_data = w_head[WIDTH+1:2];
    assign w_head_be   = w_head[1:0];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_next = r_count - 1'b1;
    end

    // Clear decisions look at occupancy after this edge's push/pop, so a write
    // accepted alongside clr_req is committed before the sweep starts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (clr_req) w_state_next = (w_count_next != '0) ? c_DRAIN : c_CLEAR;
            c_DRAIN: if (w_count_next == '0) w_state_next = c_CLEAR;
            c_CLEAR: if (r_idx == 3'd7) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            for (int i = 0; i < 8; i++) r_q[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {wr_addr, wr_data, wr_be};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                if (w_head_be[1]) r_q[w_head_addr][WIDTH-1:8] <= w_head_data[WIDTH-1:8];
                if (w_head_be[0]) r_q[w_head_addr][7:0]       <= w_head_data[7:0];
            end
            if (r_state == c_CLEAR) begin
                r_q[r_idx] <= '0;
                r_idx      <= r_idx + 1'b1;
            end else if (w_state_next == c_CLEAR) begin
                r_idx <= '0;
            end
            r_count <= w_count_next;
            r_state <= w_state_next;
            r_busy  <= (w_state_next != c_IDLE);
        end
    end

    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign q0 = r_q[0];
    assign q1 = r_q[1];
    assign q2 = r_q[2];
    assign q3 = r_q[3];
    assign q4 = r_q[4];
    assign q5 = r_q[5];
    assign q6 = r_q[6];
    assign q7 = r_q[7];

endmodule
`default_nettype wire
